aes_output_collector: RTL and testbench
=======================================

# aes_output_collector

Byte-to-block collector directly downstream of `AES_encryption`. It captures the 16 ciphertext bytes the core emits on `state_out_byte` after asserting `ready`, and assembles them into one 128-bit block. It holds up to two completed blocks in a FIFO-ordered buffer and presents them on a valid/ready interface to the consumer. Blocks that arrive while the buffer is full are dropped, and a sticky error flag is raised.

## Interface
- `MSB_FIRST`, default 1. 1: first byte captured lands in `out_data[127:120]`. 0: first byte lands in `out_data[7:0]`.
- `COUNT_W`, default 16. Width of `block_count`.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-low. All state is cleared while low.
- `core_ready`, input, 1: `ready` from `AES_encryption`.
- `core_byte`, input, 8: `state_out_byte` from `AES_encryption`.
- `clear_err`, input, 1: synchronous clear of `overrun`.
- `out_data`, output, 128: head-of-buffer block.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: consumer accepts the block.
- `busy`, output, 1: a collection is in progress.
- `overrun`, output, 1: sticky flag; a completed block was dropped.
- `block_count`, output, `COUNT_W`: number of blocks accepted into the buffer. Wraps modulo 2^`COUNT_W`.

## Operation
- Core protocol:
  - Byte 0 is valid on the cycle `core_ready` rises.
  - Bytes 1..15 follow on the next 15 consecutive cycles.
  - `core_ready` is not re-checked after the rise.
- Start detection:
  - A registered copy of `core_ready`, `rdy_q`, resets to 0.
  - A start is `core_ready & ~rdy_q`.
  - If `core_ready` is already high at reset release, the first clock edge counts as a start.
- FSM states:
  - IDLE: on a start, capture `core_byte` as byte 0, set index to 1, go to COLLECT.
  - COLLECT: capture `core_byte` at the current index and increment. When index 15 is captured, the block is complete; return to IDLE.
  - A start edge seen during COLLECT is ignored.
  - A start is accepted in the cycle immediately after completion.
- Assembly:
  - Byte k goes to bits `[127-8k -: 8]` when `MSB_FIRST`=1, or `[8k +: 8]` when `MSB_FIRST`=0.
  - The completing write uses the current `core_byte` directly. There is no extra cycle.
- Output buffer: two entries, FIFO order. `out_data`/`out_valid` reflect the head entry.
- Pop: `out_valid & out_ready` at a clock edge removes the head. Entry 1 moves to the head.
- Push: a completed block is written to the first free slot after the same-edge pop is accounted for.
  - A push and pop on the same edge with 2 entries held: the push succeeds, count stays 2, no overrun.
  - A push and pop on the same edge with 1 entry held: the new block becomes the head.
- Drop: a completed block with both entries full and no pop is discarded. `overrun` is set and `block_count` is not incremented.
- `block_count` increments by 1 on each accepted push.
- `clear_err` clears `overrun`. If `clear_err` and a drop occur on the same edge, `overrun` stays 1.
- `out_data` must not change while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values:
  - `out_data`=0, `out_valid`=0, `busy`=0, `overrun`=0, `block_count`=0.
  - FSM in IDLE, index 0, `rdy_q`=0, both buffer entries empty.
- `busy` is 1 from the edge after byte 0 is captured through the edge that captures byte 15.
- Latency:
  - Byte 0 is sampled at edge N and byte 15 at edge N+15.
  - With a free buffer slot, `out_valid`=1 from just after edge N+15.
- Throughput: one block per 16 cycles sustained, with zero bubble between blocks.
- Reset mid-collection:
  - The partial block is discarded and buffered blocks are lost.
  - After reset release, collection restarts only on a new start edge, or when `core_ready` is high at release.
- Index arithmetic is 4-bit. 15 is terminal and never wraps inside COLLECT.

## Test plan
- **Single block:** `rst` low 3 cycles, then high. Rise `core_ready` with bytes 0x00..0x0F on consecutive cycles, `out_ready`=1. Required:
  - `out_data`=0x000102030405060708090A0B0C0D0E0F, `out_valid` high 1 cycle after byte 15.
  - `block_count`=1.
- **Real core output:** drive the all-zero key/plaintext result bytes 66 E9 4B D4 EF 8A 2C 3B 88 4C FA 59 CA 34 2B 2E. Required: `out_data`=0x66E94BD4EF8A2C3B884CFA59CA342B2E.
- **Backpressure and overrun:** `out_ready`=0, three back-to-back blocks. Required:
  - After block 3: `out_valid`=1, head is block 1, `block_count`=2, `overrun`=1.
  - Release `out_ready`: block 1 then block 2 pop; block 3 never appears.
  - `clear_err`=1 then drops `overrun` to 0.
- **Pop/push collision:** buffer full, `out_ready` asserted exactly on the edge block 3 completes. Required: `overrun`=0, `block_count`=3, blocks pop in order 2, 3.
- **Reset mid-collection:** assert `rst` after byte 7 of block A, release, then send block B. Required: only block B appears, and `block_count`=1.
- **Ordering parameter:** with `MSB_FIRST`=0, bytes 0x00..0x0F give `out_data`=0x0F0E0D0C0B0A09080706050403020100.

Source files
------------

// File: rtl/aes_output_collector.sv
// Collects the 16 ciphertext bytes streamed by AES_encryption into 128-bit blocks
// and hands them out through a two-entry FIFO with a valid/ready consumer port.
module aes_output_collector #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               core_ready,
  input  logic [7:0]         core_byte,
  input  logic               clear_err,
  output logic [127:0]       out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               overrun,
  output logic [COUNT_W-1:0] block_count,
  output logic               dbg_state
);

  // Handshake: the head block transfers on any rising edge where out_valid and
  // out_ready are both high; out_data is held stable while valid waits for ready.

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic                 rdy_q, rdy_d;
  logic [127:0]         asm_q, asm_d;
  logic [127:0]         mem0_q, mem0_d;
  logic [127:0]         mem1_q, mem1_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 ovr_q, ovr_d;
  logic [COUNT_W-1:0]   bcnt_q, bcnt_d;

  logic                 start;
  logic                 done;
  logic                 pop;
  logic                 accept;
  logic                 drop;
  logic [1:0]           cnt_ap;

  function automatic logic [127:0] place(input logic [127:0] blk,
                                         input logic [3:0]   k,
                                         input logic [7:0]   b);
    logic [127:0] r;
    logic [6:0]   lo;
    r  = blk;
    lo = {k, 3'b000};
    if (MSB_FIRST) r[(7'd120 - lo) +: 8] = b;
    else           r[lo +: 8]            = b;
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    rdy_d   = core_ready;
    done    = 1'b0;
    start   = core_ready & ~rdy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          asm_d   = place(asm_q, 4'd0, core_byte);
          idx_d   = 4'd1;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // Start edges are deliberately not looked at here.
        asm_d = place(asm_q, idx_q, core_byte);
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          done    = 1'b1;
          idx_d   = 4'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The same-edge pop frees a slot before the completed block looks for one.
  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    pop    = (cnt_q != 2'd0) & out_ready;
    cnt_ap = cnt_q - {1'b0, pop};
    accept = done & (cnt_ap != 2'd2);
    drop   = done & ~accept;
    if (pop) mem0_d = mem1_q;
    if (accept) begin
      if (cnt_ap == 2'd0) mem0_d = asm_d;
      else                mem1_d = asm_d;
    end
    cnt_d  = cnt_ap + {1'b0, accept};
    ovr_d  = (ovr_q & ~clear_err) | drop;
    bcnt_d = accept ? bcnt_q + {{(COUNT_W-1){1'b0}}, 1'b1} : bcnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      rdy_q   <= 1'b0;
      asm_q   <= '0;
      mem0_q  <= '0;
      mem1_q  <= '0;
      cnt_q   <= 2'd0;
      ovr_q   <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rdy_q   <= rdy_d;
      asm_q   <= asm_d;
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign out_data    = mem0_q;
  assign out_valid   = (cnt_q != 2'd0);
  assign busy        = (state_q == S_COLLECT);
  assign overrun     = ovr_q;
  assign block_count = bcnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_aes_output_collector.sv
// Bench for aes_output_collector: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level queue model of the block buffer.
module tb_aes_output_collector;

  logic         clk;
  logic         rst;
  logic         core_ready;
  logic [7:0]   core_byte;
  logic         clear_err;
  logic         out_ready;
  logic [127:0] out_data, out_data_l;
  logic         out_valid, out_valid_l;
  logic         busy, busy_l;
  logic         overrun, overrun_l;
  logic [15:0]  block_count, block_count_l;
  logic         dbg_state, dbg_state_l;

  aes_output_collector #(.MSB_FIRST(1'b1), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .core_ready(core_ready), .core_byte(core_byte),
    .clear_err(clear_err), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .overrun(overrun),
    .block_count(block_count), .dbg_state(dbg_state)
  );

  aes_output_collector #(.MSB_FIRST(1'b0), .COUNT_W(16)) dut_lsb (
    .clk(clk), .rst(rst), .core_ready(core_ready), .core_byte(core_byte),
    .clear_err(clear_err), .out_data(out_data_l), .out_valid(out_valid_l),
    .out_ready(out_ready), .busy(busy_l), .overrun(overrun_l),
    .block_count(block_count_l), .dbg_state(dbg_state_l)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state: blocks stored in capture order, first byte in the top bits
  logic [127:0] exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  bit           m_ovr = 0;
  bit           m_busy = 0;
  int           m_cnt = 0;
  bit           rnd = 0;

  function automatic logic [127:0] rev(input logic [127:0] b);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = b[127-8*k -: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovr  = 0;
    m_busy = 0;
    m_cnt  = 0;
  endtask

  // One clock: compare DUT to model, advance model by this edge, then take the edge.
  task automatic tick(input bit first, input bit done, input logic [127:0] blk);
    bit pop;
    bit drop;
    if (rnd) begin
      out_ready = 1'($urandom_range(0, 1));
      clear_err = ($urandom_range(0, 7) == 0);
    end
    chk("out_valid", {127'b0, out_valid}, {127'b0, exp_q.size() > 0});
    chk("out_valid_lsb", {127'b0, out_valid_l}, {127'b0, exp_q.size() > 0});
    if (exp_q.size() > 0) begin
      chk("out_data", out_data, exp_q[0]);
      chk("out_data_lsb", out_data_l, rev(exp_q[0]));
    end
    chk("busy", {127'b0, busy}, {127'b0, m_busy});
    chk("overrun", {127'b0, overrun}, {127'b0, m_ovr});
    chk("block_count", {112'b0, block_count}, 128'(m_cnt % 65536));
    pop  = (exp_q.size() > 0) && out_ready;
    if (pop) void'(exp_q.pop_front());
    drop = 0;
    if (done) begin
      if (exp_q.size() < 2) begin
        exp_q.push_back(blk);
        m_cnt++;
      end else drop = 1;
    end
    m_ovr = (m_ovr && !clear_err) || drop;
    if (first) m_busy = 1;
    if (done)  m_busy = 0;
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send(input logic [127:0] blk, input int nbytes, input bit pop_last);
    for (int k = 0; k < nbytes; k++) begin
      if (k == 0)           core_ready = 1'b1;
      else if (rnd && k < 15) core_ready = 1'($urandom_range(0, 1));
      else                  core_ready = 1'b0;
      core_byte = blk[127-8*k -: 8];
      if (pop_last && k == 15) out_ready = 1'b1;
      tick(k == 0, k == 15, blk);
    end
    core_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      core_ready = 1'b0;
      core_byte  = 8'($urandom_range(0, 255));
      tick(0, 0, '0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_data", out_data, '0);
    chk("rst_out_data_lsb", out_data_l, '0);
    chk("rst_out_valid", {127'b0, out_valid}, '0);
    chk("rst_busy", {127'b0, busy}, '0);
    chk("rst_overrun", {127'b0, overrun}, '0);
    chk("rst_block_count", {112'b0, block_count}, '0);
    rst = 1'b1;
  endtask

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] a, b, c;

  initial begin
    rst        = 1'b1;
    core_ready = 1'b0;
    core_byte  = 8'h00;
    clear_err  = 1'b0;
    out_ready  = 1'b0;
    #2;

    // single block, both byte orders
    do_reset();
    out_ready = 1'b1;
    send(128'h000102030405060708090A0B0C0D0E0F, 16, 0);
    chk("single_valid", {127'b0, out_valid}, 128'd1);
    chk("single_data", out_data, 128'h000102030405060708090A0B0C0D0E0F);
    chk("single_data_lsb", out_data_l, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("single_count", {112'b0, block_count}, 128'd1);
    idle(2);

    // real core output
    send(128'h66E94BD4EF8A2C3B884CFA59CA342B2E, 16, 0);
    chk("real_data", out_data, 128'h66E94BD4EF8A2C3B884CFA59CA342B2E);
    idle(2);

    // backpressure and overrun
    do_reset();
    out_ready = 1'b0;
    a = rand_blk(); b = rand_blk(); c = rand_blk();
    send(a, 16, 0);
    send(b, 16, 0);
    send(c, 16, 0);
    chk("bp_valid", {127'b0, out_valid}, 128'd1);
    chk("bp_head", out_data, a);
    chk("bp_count", {112'b0, block_count}, 128'd2);
    chk("bp_overrun", {127'b0, overrun}, 128'd1);
    out_ready = 1'b1;
    idle(3);
    chk("bp_drained", {127'b0, out_valid}, 128'd0);
    chk("bp_overrun_sticky", {127'b0, overrun}, 128'd1);
    clear_err = 1'b1;
    idle(1);
    clear_err = 1'b0;
    chk("bp_cleared", {127'b0, overrun}, 128'd0);

    // pop/push collision on the completing edge
    do_reset();
    out_ready = 1'b0;
    a = rand_blk(); b = rand_blk(); c = rand_blk();
    send(a, 16, 0);
    send(b, 16, 0);
    send(c, 16, 1);
    chk("col_overrun", {127'b0, overrun}, 128'd0);
    chk("col_count", {112'b0, block_count}, 128'd3);
    chk("col_head", out_data, b);
    out_ready = 1'b1;
    idle(3);

    // reset in the middle of a collection
    do_reset();
    out_ready = 1'b0;
    a = rand_blk(); b = rand_blk();
    send(a, 8, 0);
    do_reset();
    send(b, 16, 0);
    chk("mid_head", out_data, b);
    chk("mid_count", {112'b0, block_count}, 128'd1);
    out_ready = 1'b1;
    idle(3);

    // randomized traffic
    do_reset();
    rnd = 1;
    for (int i = 0; i < 40; i++) begin
      send(rand_blk(), 16, 0);
      idle($urandom_range(0, 3));
    end
    rnd = 0;
    clear_err = 1'b0;
    out_ready = 1'b1;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
